conv33_window: RTL and testbench
================================

CONV33_WINDOW -- requirements
Module: conv33_window

Interface
REQ-001 Parameter IMG_W, default 28: pixels per image row, legal range 3..1024.
REQ-002 Parameter IMG_H, default 28: rows per image, legal range 3..1024.
REQ-003 Port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-low reset (reset when rst=0 at a clk rising edge).
REQ-005 Port start, input, 1 bit: single-cycle pulse that begins a frame.
REQ-006 Port pix_in, input, 8 bits signed: raster-order pixel.
REQ-007 Port pix_valid, input, 1 bit: pix_in is valid this cycle.
REQ-008 Port pix_ready, output, 1 bit: block accepts a pixel when pix_valid=1 and pix_ready=1.
REQ-009 Ports data_0_0..data_2_2, output, 8 bits signed each: 3x3 window; row 0 is oldest, column 0 is leftmost.
REQ-010 Port conv33_en, output, 1 bit: window valid this cycle, for direct connection to the conv33_calc enable.
REQ-011 Port busy, output, 1 bit: a frame is in progress.
REQ-012 Port frame_done, output, 1 bit: single-cycle pulse after the last pixel of a frame.

Function
REQ-013 The FSM SHALL have states IDLE, FILL, RUN and DONE.
REQ-014 IDLE -> FILL on start=1; start is ignored in every other state.
REQ-015 FILL -> RUN when the pixel at (row 2, col 2) is accepted.
REQ-016 FILL or RUN -> DONE when pixel (IMG_H-1, IMG_W-1) is accepted; DONE -> IDLE on the next cycle.
REQ-017 pix_ready=1 only in FILL and RUN; pixels are ignored in IDLE and DONE.
REQ-018 Column counter: increments per accepted pixel; wraps from IMG_W-1 to 0 and increments the row counter on wrap. Both counters clear on start.
REQ-019 Storage: two IMG_W-deep line buffers hold rows y-1 and y-2, plus a 3x3 shift register fed by the line-buffer outputs and pix_in.
REQ-020 On accepting pixel (y,x) with y>=2 and x>=2, the next cycle SHALL show:
- data_2_2 = p(y,x)
- data_0_0 = p(y-2,x-2)
- data_r_c = p(y-2+r, x-2+c)
- conv33_en = 1
REQ-021 Latency: exactly 1 cycle from the accepting edge to conv33_en=1; conv33_en is 0 in every other cycle.
REQ-022 A frame SHALL produce exactly (IMG_W-2)*(IMG_H-2) windows; no padding is applied.
REQ-023 Windows SHALL never span a row wrap: no conv33_en when x<2.
REQ-024 pix_valid gaps stall the counters and window; outputs hold their last values with conv33_en=0.
REQ-025 frame_done=1 for exactly one cycle, in DONE, which coincides with the final conv33_en pulse.
REQ-026 busy=1 in FILL, RUN and DONE.
REQ-027 A start pulse arriving in the same cycle as DONE SHALL be ignored.

Reset
REQ-028 rst=0 SHALL force:
- state = IDLE
- counters = 0
- data_* = 0
- conv33_en, pix_ready, busy, frame_done = 0
REQ-029 Reset mid-frame SHALL abandon the frame; no further conv33_en until a new start and a full 3-row fill. Line-buffer contents need not be cleared.

Configuration
REQ-030 Macro CONV33_WINDOW_STRIDE2_EN defined: conv33_en is asserted only when (y-2) and (x-2) are both even, giving ceil((IMG_W-2)/2)*ceil((IMG_H-2)/2) windows per frame; window contents and timing otherwise follow REQ-020.
REQ-031 Macro CONV33_WINDOW_STRIDE2_EN undefined: stride 1 as in REQ-022; the stride logic SHALL not be synthesized.

Verification
REQ-032 IMG_W=IMG_H=4, start, pixels 1..16 continuous -> 4 conv33_en pulses, one cycle after pixels 11, 12, 15 and 16; first window 1,2,3/5,6,7/9,10,11; last window 6,7,8/10,11,12/14,15,16; frame_done coincides with the last pulse.
REQ-033 Same stimulus with pix_valid=0 on alternate cycles -> identical windows, each one cycle after its accepting edge; conv33_en is never high for 2 consecutive cycles.
REQ-034 IMG_W=IMG_H=4, rst=0 after pixel 10, then start and pixels 1..16 -> no conv33_en before pixel 11 of the new frame; exactly 4 windows.
REQ-035 start pulse during RUN or DONE -> no counter change and window count unchanged; pixels offered in IDLE -> pix_ready=0 and nothing consumed.
REQ-036 CONV33_WINDOW_STRIDE2_EN defined, IMG_W=IMG_H=6, pixels 1..36 -> 4 windows with data_2_2 = 15, 17, 27, 29.
REQ-037 Pixels -128 and 127 in the window -> data ports carry the exact signed values with no sign loss.

Source files
------------

// File: rtl/conv33_window.sv
// 3x3 sliding-window generator for a raster pixel stream: two line buffers plus a 3x3 shift register.
// Optional build macro CONV33_WINDOW_STRIDE2_EN: emit only windows whose top-left corner is on even row/column.
module conv33_window #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic signed [7:0] pix_in,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic signed [7:0] data_0_0,
  output logic signed [7:0] data_0_1,
  output logic signed [7:0] data_0_2,
  output logic signed [7:0] data_1_0,
  output logic signed [7:0] data_1_1,
  output logic signed [7:0] data_1_2,
  output logic signed [7:0] data_2_0,
  output logic signed [7:0] data_2_1,
  output logic signed [7:0] data_2_2,
  output logic              conv33_en,
  output logic              busy,
  output logic              frame_done,
  output logic [1:0]        dbg_state
);

  // Handshake: a pixel is consumed on a rising edge where pix_valid=1 and pix_ready=1;
  // pix_ready depends only on the FSM state, never combinationally on pix_valid.

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  logic signed [7:0] lb0_q [IMG_W];
  logic signed [7:0] lb1_q [IMG_W];
  logic signed [7:0] win_q [3][3];
  logic              en_q;

  logic accept;
  logic last_pix;
  logic fill_done;
  logic stride_ok;
  logic win_hit;

  assign accept    = pix_valid && pix_ready;
  assign last_pix  = accept && (col_q == COL_LAST) && (row_q == ROW_LAST);
  assign fill_done = accept && (col_q == COL_TWO) && (row_q == ROW_TWO);

`ifdef CONV33_WINDOW_STRIDE2_EN
  // (y-2) and (x-2) even is the same as y and x even.
  assign stride_ok = ~row_q[0] & ~col_q[0];
`else
  assign stride_ok = 1'b1;
`endif

  assign win_hit = accept && (row_q >= ROW_TWO) && (col_q >= COL_TWO) && stride_ok;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_FILL;
      S_FILL: begin
        if (last_pix)       state_d = S_DONE;
        else if (fill_done) state_d = S_RUN;
      end
      S_RUN:  if (last_pix) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pix_ready  = (state_q == S_FILL) || (state_q == S_RUN);
    busy       = (state_q != S_IDLE);
    frame_done = (state_q == S_DONE);
    dbg_state  = state_q;
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (state_q == S_IDLE && start) begin
      col_d = '0;
      row_d = '0;
    end else if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q <= '0;
      row_q <= '0;
      en_q  <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      en_q  <= win_hit;
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= lb1_q[col_q];
        win_q[1][2] <= lb0_q[col_q];
        win_q[2][2] <= pix_in;
      end
    end
  end

  // Line buffers are never reset: stale contents are only read once rows y-1 and y-2 are rewritten.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= pix_in;
    end
  end

  assign conv33_en = en_q;
  assign data_0_0  = win_q[0][0];
  assign data_0_1  = win_q[0][1];
  assign data_0_2  = win_q[0][2];
  assign data_1_0  = win_q[1][0];
  assign data_1_1  = win_q[1][1];
  assign data_1_2  = win_q[1][2];
  assign data_2_0  = win_q[2][0];
  assign data_2_1  = win_q[2][1];
  assign data_2_2  = win_q[2][2];

endmodule

// File: tb/tb_conv33_window.sv
// Randomized scoreboard bench for conv33_window: a frame-array reference model predicts every window.
module tb_conv33_window;

`ifdef CONV33_WINDOW_STRIDE2_EN
  localparam int W = 6;
  localparam int H = 6;
  localparam bit STRIDE2 = 1'b1;
  localparam int EXP_WIN = ((W - 1) / 2) * ((H - 1) / 2);
`else
  localparam int W = 4;
  localparam int H = 4;
  localparam bit STRIDE2 = 1'b0;
  localparam int EXP_WIN = (W - 2) * (H - 2);
`endif

  logic              clk;
  logic              rst;
  logic              start;
  logic signed [7:0] pix_in;
  logic              pix_valid;
  logic              pix_ready;
  logic signed [7:0] data_0_0, data_0_1, data_0_2;
  logic signed [7:0] data_1_0, data_1_1, data_1_2;
  logic signed [7:0] data_2_0, data_2_1, data_2_2;
  logic              conv33_en;
  logic              busy;
  logic              frame_done;
  logic [1:0]        dbg_state;

  conv33_window #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .data_0_0(data_0_0), .data_0_1(data_0_1), .data_0_2(data_0_2),
    .data_1_0(data_1_0), .data_1_1(data_1_1), .data_1_2(data_1_2),
    .data_2_0(data_2_0), .data_2_1(data_2_1), .data_2_2(data_2_2),
    .conv33_en(conv33_en), .busy(busy), .frame_done(frame_done), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [71:0]       exp_q[$];
  int                n_cmp = 0;
  int                n_bad = 0;
  int                win_cnt = 0;
  bit                mon_on = 1'b0;
  bit                gap_mode = 1'b0;
  bit                prev_en = 1'b0;

  // reference model state
  logic signed [7:0] frame_mem [W*H];
  bit                m_active = 1'b0;
  bit                m_done = 1'b0;
  int                m_idx = 0;

  logic [71:0] dut_win;
  assign dut_win = {data_0_0, data_0_1, data_0_2, data_1_0, data_1_1, data_1_2,
                    data_2_0, data_2_1, data_2_2};

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pixels stored by raster index, window rebuilt from (y,x) arithmetic.
  always @(posedge clk) begin
    if (!rst) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      exp_q.delete();
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        m_idx    = 0;
      end
    end else if (pix_valid) begin
      int y, x;
      logic [71:0] ew;
      frame_mem[m_idx] = pix_in;
      y = m_idx / W;
      x = m_idx % W;
      if (y >= 2 && x >= 2 && (!STRIDE2 || (((y - 2) % 2 == 0) && ((x - 2) % 2 == 0)))) begin
        ew = '0;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            ew = {ew[63:0], frame_mem[(y - 2 + r) * W + (x - 2 + c)]};
        exp_q.push_back(ew);
      end
      m_idx++;
      if (m_idx == W * H) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end
  end

  // monitor
  always @(negedge clk) begin
    if (mon_on) begin
      chk("pix_ready", {71'd0, pix_ready}, {71'd0, m_active});
      chk("busy", {71'd0, busy}, {71'd0, m_active || m_done});
      chk("frame_done", {71'd0, frame_done}, {71'd0, m_done});
      if (conv33_en) begin
        if (exp_q.size() == 0) begin
          chk("spurious_window", {71'd0, conv33_en}, 72'd0);
        end else begin
          chk("window", dut_win, exp_q.pop_front());
          win_cnt++;
        end
        if (gap_mode) chk("back_to_back_en", {71'd0, prev_en}, 72'd0);
      end
      prev_en = conv33_en;
    end
  end

  // driver tasks
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // gap: 0 none, 1 alternate, 2 random; rnd: random pixel values; stop_at: pixels sent (-1 = all)
  task automatic send_frame(input int gap, input bit rnd, input int start_at, input int stop_at);
    int n;
    n = (stop_at < 0) ? W * H : stop_at;
    for (int i = 0; i < n; i++) begin
      int g;
      g = (gap == 1) ? ((i == 0) ? 0 : 1) : (gap == 2) ? $urandom_range(0, 2) : 0;
      pix_valid = 1'b0;
      if (g > 0) tick(g);
      pix_valid = 1'b1;
      if (rnd) begin
        if (i == W + 1)           pix_in = 8'sh80;
        else if (i == 2 * W + 2)  pix_in = 8'sh7f;
        else                      pix_in = 8'($urandom_range(0, 255));
      end else begin
        pix_in = 8'(i + 1);
      end
      start = (i == start_at);
      tick(1);
      start = 1'b0;
    end
    pix_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    pix_in    = '0;
    pix_valid = 1'b0;
    tick(3);
    chk("reset_data", dut_win, 72'd0);
    chk("reset_en", {71'd0, conv33_en}, 72'd0);
    chk("reset_state", {70'd0, dbg_state}, 72'd0);
    mon_on = 1'b1;
    rst = 1'b1;
    tick(2);

    // continuous sequential frame
    win_cnt = 0;
    do_start();
    send_frame(0, 1'b0, -1, -1);
    tick(4);
    chk("count_continuous", 72'(win_cnt), 72'(EXP_WIN));

    // alternating valid gaps
    win_cnt = 0;
    gap_mode = 1'b1;
    do_start();
    send_frame(1, 1'b0, -1, -1);
    tick(4);
    gap_mode = 1'b0;
    chk("count_gapped", 72'(win_cnt), 72'(EXP_WIN));

    // reset after pixel 10, then a full new frame
    do_start();
    send_frame(0, 1'b0, -1, 10);
    rst = 1'b0;
    tick(1);
    chk("midreset_data", dut_win, 72'd0);
    chk("midreset_busy", {71'd0, busy}, 72'd0);
    rst = 1'b1;
    tick(2);
    win_cnt = 0;
    do_start();
    send_frame(0, 1'b0, -1, -1);
    tick(4);
    chk("count_after_reset", 72'(win_cnt), 72'(EXP_WIN));

    // start during RUN and during DONE, then pixels offered in IDLE
    win_cnt = 0;
    do_start();
    send_frame(0, 1'b0, 2 * W + 3, -1);
    do_start();
    chk("start_in_done_busy", {71'd0, busy}, 72'd0);
    pix_valid = 1'b1;
    pix_in = 8'sh55;
    tick(5);
    pix_valid = 1'b0;
    chk("count_start_ignored", 72'(win_cnt), 72'(EXP_WIN));
    win_cnt = 0;
    do_start();
    send_frame(0, 1'b0, -1, -1);
    tick(4);
    chk("count_after_idle_pixels", 72'(win_cnt), 72'(EXP_WIN));

    // randomized frames with extreme signed values and random stalls
    for (int f = 0; f < 4; f++) begin
      win_cnt = 0;
      do_start();
      send_frame(2, 1'b1, $urandom_range(0, W * H + 5), -1);
      tick(4);
      chk("count_random", 72'(win_cnt), 72'(EXP_WIN));
    end

    chk("queue_drained", 72'(exp_q.size()), 72'd0);
    mon_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
